led_sbox_layer_ctrl: RTL and testbench
======================================

// Module: led_sbox_layer_ctrl
// PURPOSE
//  Sequences one LED SubCells layer over a 64-bit, 3-share masked state through one shared
//  TwoSbox instance (two masked PRESENT sboxes, 8 bits/cycle, LAT-stage pipeline, no enable).
//  Issues 8 byte chunks and pulls 90 fresh random bits per issue from the PRNG handshake.
//  Tracks in-flight chunks with a valid pipe, reassembles the 3 output shares and signals done.
//  Sits between the LED round FSM and the TwoSbox datapath. Shares are never combined here.
// PARAMETERS
//  LAT    3   TwoSbox pipeline depth, in cycles from sb_in* to sb_out*; must be >= 1
//  RND_W  90  random bits consumed per issue (2 x 45)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   start pulse; sampled only in IDLE
//  in_s1..3   in   64  input state shares, latched on accepted start
//  busy       out  1   high in ISSUE and DRAIN
//  done       out  1   one-cycle pulse; out_s* are valid from this cycle
//  out_s1..3  out  64  output state shares, held until the next accepted start
//  rnd_valid  in   1   PRNG word available
//  rnd_ready  out  1   controller consumes rnd_data this cycle when rnd_valid is also high
//  rnd_data   in   90  fresh randomness
//  sb_in1..3  out  8   TwoSbox input shares
//  sb_r       out  90  TwoSbox randomness
//  sb_out1..3 in   8   TwoSbox output shares
// BEHAVIOUR
//  Reset: all registers are cleared; state=IDLE; busy=done=rnd_ready=0.
//    out_s*, sb_in*, sb_r and the valid pipe all read 0.
//  FSM states: IDLE, ISSUE, DRAIN, DONE.
//   IDLE -> ISSUE on start.
//    Load in_s* into three 64-bit shift registers; clear out_s*, issue_cnt and coll_cnt.
//   ISSUE: rnd_ready=1.
//    Issue cycle (rnd_valid=1): sb_in* = low byte of each share register; sb_r = rnd_data.
//    On an issue cycle the share registers shift right by 8 (zero fill), issue_cnt++, vpipe[0]<=1.
//    Bubble (rnd_valid=0): sb_in*=0, sb_r=0, vpipe[0]<=0, no shift.
//    -> DRAIN when an issue happens with issue_cnt==7.
//   DRAIN: rnd_ready=0, sb_in*=0, sb_r=0; -> DONE when coll_cnt reaches 8.
//   DONE: done=1 for one cycle, then -> IDLE. start is ignored outside IDLE (no queuing).
//  Valid pipe: vpipe is LAT bits wide and shifts every cycle in all states.
//  Collection: a chunk is collected in any state when vpipe[LAT-1]=1.
//    sb_out* is written to out_s*[8*coll_cnt+7 -: 8], then coll_cnt++.
//    Collection overlaps ISSUE.
//  Chunk order: chunk k = bits [8k+7:8k], issued and collected k=0..7.
//    Per chunk, bits [3:0] go to sbox S1 and bits [7:4] go to sbox S2.
//  Latency: start is accepted at edge 0; with rnd_valid held high, chunk k is on sb_in in cycle k+1.
//    That chunk is collected at the end of cycle k+1+LAT; done is high in cycle LAT+9 (12 for LAT=3).
//    Each bubble adds one cycle.
//  Counters: issue_cnt and coll_cnt are 4-bit and never wrap; both saturate at 8 by FSM construction.
//  The 90-bit word handshake is consumed exactly 8 times per layer; no randomness is reused.
//  Reset mid-operation: return to IDLE and clear vpipe, so stale TwoSbox outputs are never collected.
//    The next start runs a clean layer.
// TESTING
//  1. in_s1=0, s2=s3=0, rnd_valid=1, start at cycle 0.
//     -> done pulses in cycle 12; out_s1^out_s2^out_s3 = 64'hCCCC_CCCC_CCCC_CCCC.
//  2. Shares XOR to 64'h0123456789ABCDEF, random masks and rnd_data.
//     -> XOR of out shares = 64'hC56B90AD3EF84712; repeat over 1000 random masks.
//  3. rnd_valid low in cycles 2, 5 and 6 -> exactly 8 rnd handshakes; done in cycle 15; result as in 2.
//  4. start re-pulsed while busy, and in the DONE cycle -> ignored; single done pulse; out_s* unchanged.
//  5. rst_n low in cycle 6 of a layer, released, then new start with the test-2 input.
//     -> busy/done/vpipe read 0 during reset; the new layer result matches test 2 exactly.
//  6. Compile with LAT=1 and LAT=5 using matching sbox models
//     -> done in cycle 10 and cycle 14 respectively; results correct.

Source files
------------

// File: rtl/led_sbox_layer_ctrl_if.sv
// PRNG handshake and TwoSbox datapath bundle seen by the SubCells layer controller.
// The master modport is the controller side; the slave modport is the PRNG/TwoSbox side.
interface led_sbox_layer_ctrl_if #(
    parameter int RND_W = 90
);
    logic             rnd_valid;
    logic             rnd_ready;
    logic [RND_W-1:0] rnd_data;
    logic [7:0]       sb_in1;
    logic [7:0]       sb_in2;
    logic [7:0]       sb_in3;
    logic [RND_W-1:0] sb_r;
    logic [7:0]       sb_out1;
    logic [7:0]       sb_out2;
    logic [7:0]       sb_out3;

    modport master (
        input  rnd_valid, rnd_data, sb_out1, sb_out2, sb_out3,
        output rnd_ready, sb_in1, sb_in2, sb_in3, sb_r
    );

    modport slave (
        output rnd_valid, rnd_data, sb_out1, sb_out2, sb_out3,
        input  rnd_ready, sb_in1, sb_in2, sb_in3, sb_r
    );
endinterface

// File: rtl/led_sbox_layer_ctrl.sv
// LED SubCells layer controller: streams a 3-share 64-bit state through a shared pipelined
// TwoSbox one byte per issue and reassembles the three output shares without combining them.
module led_sbox_layer_ctrl #(
    parameter int LAT   = 3,
    parameter int RND_W = 90
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [63:0]           in_s1,
    input  logic [63:0]           in_s2,
    input  logic [63:0]           in_s3,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           out_s1,
    output logic [63:0]           out_s2,
    output logic [63:0]           out_s3,
    led_sbox_layer_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [63:0]      sh1;
    logic [63:0]      sh2;
    logic [63:0]      sh3;
    logic [3:0]       issue_cnt;
    logic [3:0]       coll_cnt;
    logic [LAT-1:0]   vpipe;
    logic             issue;
    logic             collect;

    assign issue   = (state == ISSUE) && bus.rnd_valid;
    assign collect = vpipe[LAT-1];

    // Bubbles and non-issue states drive zero so the sbox never sees stale shares or reused randomness.
    assign bus.sb_in1 = issue ? sh1[7:0] : 8'h00;
    assign bus.sb_in2 = issue ? sh2[7:0] : 8'h00;
    assign bus.sb_in3 = issue ? sh3[7:0] : 8'h00;
    assign bus.sb_r   = issue ? bus.rnd_data : {RND_W{1'b0}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh1       <= '0;
            sh2       <= '0;
            sh3       <= '0;
            out_s1    <= '0;
            out_s2    <= '0;
            out_s3    <= '0;
            issue_cnt <= '0;
            coll_cnt  <= '0;
            vpipe     <= '0;
        end else begin
            state <= state_nxt;
            vpipe <= (vpipe << 1) | LAT'(issue);
            if (issue) begin
                sh1       <= {8'h00, sh1[63:8]};
                sh2       <= {8'h00, sh2[63:8]};
                sh3       <= {8'h00, sh3[63:8]};
                issue_cnt <= issue_cnt + 4'd1;
            end
            if (collect) begin
                out_s1[{coll_cnt[2:0], 3'b000} +: 8] <= bus.sb_out1;
                out_s2[{coll_cnt[2:0], 3'b000} +: 8] <= bus.sb_out2;
                out_s3[{coll_cnt[2:0], 3'b000} +: 8] <= bus.sb_out3;
                coll_cnt <= coll_cnt + 4'd1;
            end
            // An accepted start owns the registers for the new layer.
            if ((state == IDLE) && start) begin
                sh1       <= in_s1;
                sh2       <= in_s2;
                sh3       <= in_s3;
                out_s1    <= '0;
                out_s2    <= '0;
                out_s3    <= '0;
                issue_cnt <= '0;
                coll_cnt  <= '0;
            end
        end
    end

    // The final collection edge moves straight to DONE so done lands LAT+1 cycles after the last issue.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        bus.rnd_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy          = 1'b1;
                bus.rnd_ready = 1'b1;
                if (issue && (issue_cnt == 4'd7)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (collect && (coll_cnt == 4'd7)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_led_sbox_layer_ctrl.sv
// Directed bench for led_sbox_layer_ctrl with a behavioural masked TwoSbox model of depth LAT.
// Output shares are checked through their XOR against hand-computed PRESENT sbox layers.
module tb_led_sbox_layer_ctrl;
    localparam int          LAT = 3;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'hC56B90AD3EF84712;
    localparam logic [63:0] ZC  = 64'hCCCCCCCCCCCCCCCC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] in_s1 = '0;
    logic [63:0] in_s2 = '0;
    logic [63:0] in_s3 = '0;
    logic        busy;
    logic        done;
    logic [63:0] out_s1;
    logic [63:0] out_s2;
    logic [63:0] out_s3;

    int          checks = 0;
    int          passes = 0;
    int          edges = 0;
    int          hs_total = 0;
    int          hs_base = 0;
    int          sbr_bad = 0;
    int          sbr_base = 0;
    int          mon_idx;
    logic [63:0] iss1;
    logic [63:0] iss2;
    logic [63:0] iss3;

    led_sbox_layer_ctrl_if #(.RND_W(90)) bus ();

    led_sbox_layer_ctrl #(.LAT(LAT), .RND_W(90)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in_s1  (in_s1),
        .in_s2  (in_s2),
        .in_s3  (in_s3),
        .busy   (busy),
        .done   (done),
        .out_s1 (out_s1),
        .out_s2 (out_s2),
        .out_s3 (out_s3),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges++;

    function automatic logic [3:0] present_s(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    // TwoSbox model: unmask, apply PRESENT per nibble, remask with fresh bits from sb_r.
    logic [7:0] sx;
    logic [7:0] sy;
    logic [7:0] m1;
    logic [7:0] m2;
    logic [7:0] p1 [LAT];
    logic [7:0] p2 [LAT];
    logic [7:0] p3 [LAT];

    assign sx = bus.sb_in1 ^ bus.sb_in2 ^ bus.sb_in3;
    assign sy = {present_s(sx[7:4]), present_s(sx[3:0])};
    assign m1 = bus.sb_r[7:0];
    assign m2 = bus.sb_r[52:45];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            p1[i] <= p1[i-1];
            p2[i] <= p2[i-1];
            p3[i] <= p3[i-1];
        end
        p1[0] <= sy ^ m1 ^ m2;
        p2[0] <= m1;
        p3[0] <= m2;
    end

    assign bus.sb_out1 = p1[LAT-1];
    assign bus.sb_out2 = p2[LAT-1];
    assign bus.sb_out3 = p3[LAT-1];

    // Record every handshake: which bytes went to the sbox and whether sb_r carried rnd_data.
    always @(negedge clk) begin
        if (bus.rnd_valid && bus.rnd_ready) begin
            mon_idx = hs_total - hs_base;
            if (mon_idx >= 0 && mon_idx < 8) begin
                iss1[mon_idx*8 +: 8] = bus.sb_in1;
                iss2[mon_idx*8 +: 8] = bus.sb_in2;
                iss3[mon_idx*8 +: 8] = bus.sb_in3;
            end
            if (bus.sb_r !== bus.rnd_data) sbr_bad++;
            hs_total++;
        end
    end

    function automatic logic [89:0] rand90();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[89:0];
    endfunction

    function automatic logic [63:0] rand64();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t;
    endfunction

    // Runs one layer for ncyc cycles; bubbles/restarts are bitmaps indexed by cycle number.
    task automatic run_layer(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             input logic [63:0] bubbles, input logic [63:0] restarts,
                             input int ncyc, output int done_cyc, output int done_cnt,
                             output logic [63:0] early_or);
        int p;
        int cyc;
        hs_base  = hs_total;
        sbr_base = sbr_bad;
        done_cyc = -1;
        done_cnt = 0;
        early_or = '1;
        @(posedge clk);
        #1;
        in_s1 = a;
        in_s2 = b;
        in_s3 = c;
        start = 1'b1;
        bus.rnd_valid = 1'b1;
        bus.rnd_data = rand90();
        p = edges;
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk);
            #1;
            cyc = edges - p;
            start = (cyc < 64) ? restarts[cyc] : 1'b0;
            bus.rnd_valid = (cyc < 64) ? !bubbles[cyc] : 1'b1;
            bus.rnd_data = rand90();
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 1) early_or = out_s1 | out_s2 | out_s3;
        end
        start = 1'b0;
        bus.rnd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passes++;
        checks++; if (bus.rnd_ready !== 1'b0) $display("[TB] FAIL reset_rnd_ready: got %b expected 0", bus.rnd_ready); else passes++;
        checks++; if ((out_s1 | out_s2 | out_s3) !== 64'h0) $display("[TB] FAIL reset_out: got %h expected 0", out_s1 | out_s2 | out_s3); else passes++;
        checks++; if ({bus.sb_in1, bus.sb_in2, bus.sb_in3} !== 24'h0) $display("[TB] FAIL reset_sb_in: got %h expected 0", {bus.sb_in1, bus.sb_in2, bus.sb_in3}); else passes++;
        checks++; if (bus.sb_r !== 90'h0) $display("[TB] FAIL reset_sb_r: got %h expected 0", bus.sb_r); else passes++;
    endtask

    task automatic test_zero_state();
        int dc;
        int dn;
        logic [63:0] eo;
        run_layer(64'h0, 64'h0, 64'h0, 64'h0, 64'h0, LAT + 12, dc, dn, eo);
        checks++; if (dc !== LAT + 9) $display("[TB] FAIL zero_done_cycle: got %0d expected %0d", dc, LAT + 9); else passes++;
        checks++; if (dn !== 1) $display("[TB] FAIL zero_done_pulses: got %0d expected 1", dn); else passes++;
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== ZC) $display("[TB] FAIL zero_result: got %h expected %h", out_s1 ^ out_s2 ^ out_s3, ZC); else passes++;
        checks++; if ((hs_total - hs_base) !== 8) $display("[TB] FAIL zero_handshakes: got %0d expected 8", hs_total - hs_base); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL zero_busy_after: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_random_masks();
        int dc;
        int dn;
        logic [63:0] eo;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        for (int i = 0; i < 1000; i++) begin
            a = rand64();
            b = rand64();
            c = PT ^ a ^ b;
            run_layer(a, b, c, 64'h0, 64'h0, LAT + 11, dc, dn, eo);
            checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CT) $display("[TB] FAIL masks_result[%0d]: got %h expected %h", i, out_s1 ^ out_s2 ^ out_s3, CT); else passes++;
            if (i == 0) begin
                checks++; if (eo !== 64'h0) $display("[TB] FAIL masks_out_cleared: got %h expected 0", eo); else passes++;
                checks++; if (dc !== LAT + 9) $display("[TB] FAIL masks_done_cycle: got %0d expected %0d", dc, LAT + 9); else passes++;
                checks++; if (iss1 !== a) $display("[TB] FAIL masks_issue_s1: got %h expected %h", iss1, a); else passes++;
                checks++; if (iss2 !== b) $display("[TB] FAIL masks_issue_s2: got %h expected %h", iss2, b); else passes++;
                checks++; if (iss3 !== c) $display("[TB] FAIL masks_issue_s3: got %h expected %h", iss3, c); else passes++;
                checks++; if ((sbr_bad - sbr_base) !== 0) $display("[TB] FAIL masks_sb_r: got %0d bad words expected 0", sbr_bad - sbr_base); else passes++;
            end
        end
    endtask

    task automatic test_bubbles();
        int dc;
        int dn;
        logic [63:0] eo;
        logic [63:0] a;
        logic [63:0] b;
        a = rand64();
        b = rand64();
        run_layer(a, b, PT ^ a ^ b, 64'h64, 64'h0, LAT + 16, dc, dn, eo);
        checks++; if ((hs_total - hs_base) !== 8) $display("[TB] FAIL bubble_handshakes: got %0d expected 8", hs_total - hs_base); else passes++;
        checks++; if (dc !== LAT + 12) $display("[TB] FAIL bubble_done_cycle: got %0d expected %0d", dc, LAT + 12); else passes++;
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CT) $display("[TB] FAIL bubble_result: got %h expected %h", out_s1 ^ out_s2 ^ out_s3, CT); else passes++;
        checks++; if (iss1 !== a) $display("[TB] FAIL bubble_issue_s1: got %h expected %h", iss1, a); else passes++;
        checks++; if ((sbr_bad - sbr_base) !== 0) $display("[TB] FAIL bubble_sb_r: got %0d bad words expected 0", sbr_bad - sbr_base); else passes++;
    endtask

    task automatic test_restart_ignored();
        int dc;
        int dn;
        logic [63:0] eo;
        logic [63:0] rs;
        rs = '0;
        rs[5] = 1'b1;
        rs[LAT + 9] = 1'b1;
        run_layer(64'h0, PT, 64'h0, 64'h0, rs, LAT + 18, dc, dn, eo);
        checks++; if (dn !== 1) $display("[TB] FAIL restart_done_pulses: got %0d expected 1", dn); else passes++;
        checks++; if (dc !== LAT + 9) $display("[TB] FAIL restart_done_cycle: got %0d expected %0d", dc, LAT + 9); else passes++;
        checks++; if ((hs_total - hs_base) !== 8) $display("[TB] FAIL restart_handshakes: got %0d expected 8", hs_total - hs_base); else passes++;
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CT) $display("[TB] FAIL restart_result_held: got %h expected %h", out_s1 ^ out_s2 ^ out_s3, CT); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL restart_busy_after: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_reset_mid();
        int dc;
        int dn;
        int p;
        logic [63:0] eo;
        logic [63:0] a;
        logic [63:0] b;
        @(posedge clk);
        #1;
        in_s1 = 64'hFFFF_0000_FFFF_0000;
        in_s2 = 64'h1234_5678_9ABC_DEF0;
        in_s3 = 64'h0;
        start = 1'b1;
        bus.rnd_valid = 1'b1;
        p = edges;
        for (int n = 0; n < 20 && (edges - p) < 6; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            bus.rnd_data = rand90();
        end
        rst_n = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL midreset_done: got %b expected 0", done); else passes++;
        checks++; if (dut.vpipe !== '0) $display("[TB] FAIL midreset_vpipe: got %b expected 0", dut.vpipe); else passes++;
        checks++; if (out_s1 !== 64'h0) $display("[TB] FAIL midreset_out: got %h expected 0", out_s1); else passes++;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dut.vpipe !== '0) $display("[TB] FAIL midreset_vpipe_held: got %b expected 0", dut.vpipe); else passes++;
        rst_n = 1'b1;
        a = rand64();
        b = rand64();
        run_layer(a, b, PT ^ a ^ b, 64'h0, 64'h0, LAT + 12, dc, dn, eo);
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CT) $display("[TB] FAIL midreset_result: got %h expected %h", out_s1 ^ out_s2 ^ out_s3, CT); else passes++;
        checks++; if (dc !== LAT + 9) $display("[TB] FAIL midreset_done_cycle: got %0d expected %0d", dc, LAT + 9); else passes++;
        checks++; if (dn !== 1) $display("[TB] FAIL midreset_done_pulses: got %0d expected 1", dn); else passes++;
    endtask

    initial begin
        bus.rnd_valid = 1'b0;
        bus.rnd_data  = '0;
        test_reset();
        test_zero_state();
        test_random_masks();
        test_bubbles();
        test_restart_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
